// File: rtl/clk_ratio_pkg.sv
// Shared types and helpers for the clock ratio meter.
package clk_ratio_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_ACQ  = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    // Unsigned magnitude of a - b, one bit wider than the operands so it never wraps.
    function automatic logic [32:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
    endfunction

endpackage

// File: rtl/clk_ratio_meter_sync_edge_det.sv
// Two-flop synchroniser for an asynchronous input followed by a rising-edge pulse.
module sync_edge_det (
    input  logic clk_in,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic stage1;
    logic stage2;
    logic stage3;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            stage1 <= 1'b0;
            stage2 <= 1'b0;
            stage3 <= 1'b0;
        end else begin
            stage1 <= d;
            stage2 <= stage1;
            stage3 <= stage2;
        end
    end

    assign q    = stage2;
    assign rise = stage2 & ~stage3;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures the period of a slow clock in clk_in cycles, flags lock and timeout.
// Optional duty measurement (high_time) is built when CLK_RATIO_DUTY_EN is defined.
module clk_ratio_meter
    import clk_ratio_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int LOCK_COUNT = 4,
    parameter int TOL        = 0
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] ratio,
    output logic             ratio_valid,
    output logic             locked,
    output logic             timeout,
    output logic [CNT_W-1:0] high_time,
    output state_t           state_dbg
);

    localparam int              MW      = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0]   LOCK_M  = MW'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic sync_q;
    logic e;

    sync_edge_det u_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .d      (sig_in),
        .q      (sync_q),
        .rise   (e)
    );

    state_t           state, state_nxt;
    logic [CNT_W-1:0] period_cnt, period_cnt_nxt;
    logic [MW-1:0]    match_cnt, match_cnt_nxt;
    logic             first_q, first_nxt;
    logic [CNT_W-1:0] ratio_nxt;
    logic             ratio_valid_nxt, locked_nxt, timeout_nxt;
    logic             capture;
    logic             is_match;

    assign is_match  = abs_diff(32'(period_cnt), 32'(ratio)) <= 33'(TOL);
    assign state_dbg = state;

    // ratio_valid is a one-cycle qualifier with no ready: ratio, locked and
    // ratio_valid change together, and a consumer that misses the pulse misses that sample.
    always_comb begin
        state_nxt       = state;
        period_cnt_nxt  = period_cnt;
        match_cnt_nxt   = match_cnt;
        first_nxt       = first_q;
        ratio_nxt       = ratio;
        ratio_valid_nxt = 1'b0;
        locked_nxt      = locked;
        timeout_nxt     = 1'b0;
        capture         = 1'b0;
        case (state)
            S_WAIT: begin
                if (e) begin
                    state_nxt      = S_ACQ;
                    period_cnt_nxt = CNT_W'(1);
                    match_cnt_nxt  = '0;
                    first_nxt      = 1'b1;
                    locked_nxt     = 1'b0;
                end
            end
            S_ACQ, S_LOCK: begin
                if (e) begin
                    capture         = 1'b1;
                    ratio_nxt       = period_cnt;
                    ratio_valid_nxt = 1'b1;
                    period_cnt_nxt  = CNT_W'(1);
                    first_nxt       = 1'b0;
                    // The first period after S_WAIT has no valid predecessor to compare against.
                    if (!first_q && is_match) begin
                        if (match_cnt != LOCK_M) begin
                            match_cnt_nxt = match_cnt + 1'b1;
                        end
                        if (match_cnt >= LOCK_M - 1'b1) begin
                            state_nxt  = S_LOCK;
                            locked_nxt = 1'b1;
                        end
                    end else begin
                        match_cnt_nxt = '0;
                        locked_nxt    = 1'b0;
                        state_nxt     = S_ACQ;
                    end
                end else if (period_cnt == CNT_MAX) begin
                    timeout_nxt   = 1'b1;
                    locked_nxt    = 1'b0;
                    match_cnt_nxt = '0;
                    state_nxt     = S_WAIT;
                end else begin
                    period_cnt_nxt = period_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state       <= S_WAIT;
            period_cnt  <= '0;
            match_cnt   <= '0;
            first_q     <= 1'b0;
            ratio       <= '0;
            ratio_valid <= 1'b0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nxt;
            period_cnt  <= period_cnt_nxt;
            match_cnt   <= match_cnt_nxt;
            first_q     <= first_nxt;
            ratio       <= ratio_nxt;
            ratio_valid <= ratio_valid_nxt;
            locked      <= locked_nxt;
            timeout     <= timeout_nxt;
        end
    end

`ifdef CLK_RATIO_DUTY_EN
    logic [CNT_W-1:0] high_cnt;

    // The edge cycle itself is high, so a fresh period starts counting at 1.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            high_cnt  <= '0;
            high_time <= '0;
        end else if (e) begin
            if (capture) begin
                high_time <= high_cnt;
            end
            high_cnt <= CNT_W'(1);
        end else if (sync_q && high_cnt != CNT_MAX) begin
            high_cnt <= high_cnt + 1'b1;
        end
    end
`else
    logic duty_unused;
    assign duty_unused = sync_q ^ capture;
    assign high_time   = '0;
`endif

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter: lock, ratio change, timeout, reset, tolerance, duty.
module tb_clk_ratio_meter;
    import clk_ratio_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic sig_main, sig8, sig_tol;

    logic [15:0] ratio_main, high_main;
    logic        rv_main, lk_main, to_main;
    state_t      st_main;

    logic [7:0]  ratio8, high8;
    logic        rv8, lk8, to8;
    state_t      st8;

    logic [15:0] ratio_tol, high_tol;
    logic        rv_tol, lk_tol, to_tol;
    state_t      st_tol;

    int vec_cnt = 0;
    int err_cnt = 0;

    clk_ratio_meter #(.CNT_W(16), .LOCK_COUNT(4), .TOL(0)) u_dut (
        .clk_in(clk), .rst(rst), .sig_in(sig_main), .ratio(ratio_main), .ratio_valid(rv_main),
        .locked(lk_main), .timeout(to_main), .high_time(high_main), .state_dbg(st_main)
    );

    clk_ratio_meter #(.CNT_W(8), .LOCK_COUNT(4), .TOL(0)) u_dut8 (
        .clk_in(clk), .rst(rst), .sig_in(sig8), .ratio(ratio8), .ratio_valid(rv8),
        .locked(lk8), .timeout(to8), .high_time(high8), .state_dbg(st8)
    );

    clk_ratio_meter #(.CNT_W(16), .LOCK_COUNT(4), .TOL(1)) u_tol (
        .clk_in(clk), .rst(rst), .sig_in(sig_tol), .ratio(ratio_tol), .ratio_valid(rv_tol),
        .locked(lk_tol), .timeout(to_tol), .high_time(high_tol), .state_dbg(st_tol)
    );

    function automatic logic [15:0] duty_exp(input int hi);
`ifdef CLK_RATIO_DUTY_EN
        return 16'(hi);
`else
        return (hi > 0) ? 16'd0 : 16'd0;
`endif
    endfunction

    // One sig_in period of n cycles (high for hi) starting with a rise; outputs sampled
    // 1 ns after the third posedge, when the capture for this rise is visible.
    task automatic drive_period(input int which, input int n, input int hi,
                                output logic v, output logic [15:0] r,
                                output logic l, output logic [15:0] h);
        v = 1'b0; r = '0; l = 1'b0; h = '0;
        for (int c = 0; c < n; c++) begin
            if (c == 3) begin
                case (which)
                    0: begin v = rv_main; r = ratio_main; l = lk_main; h = high_main; end
                    1: begin v = rv8; r = {8'd0, ratio8}; l = lk8; h = {8'd0, high8}; end
                    default: begin v = rv_tol; r = ratio_tol; l = lk_tol; h = high_tol; end
                endcase
            end
            case (which)
                0: sig_main = (c < hi);
                1: sig8 = (c < hi);
                default: sig_tol = (c < hi);
            endcase
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        vec_cnt++;
        if (ratio_main !== 16'd0 || rv_main !== 1'b0 || lk_main !== 1'b0 || to_main !== 1'b0
            || high_main !== 16'd0 || st_main !== S_WAIT) begin
            err_cnt++;
            $display("FAIL reset: ratio=%0d valid=%b locked=%b timeout=%b high=%0d state=%0d, want all 0/S_WAIT",
                     ratio_main, rv_main, lk_main, to_main, high_main, st_main);
        end
    endtask

    // Lock sequence on DIV=10: rise k captures period k-1; locked with the 6th rise.
    task automatic test_lock(input string name);
        logic v, l;
        logic [15:0] r, h;
        for (int k = 1; k <= 7; k++) begin
            drive_period(0, 10, 5, v, r, l, h);
            vec_cnt++;
            if (v !== (k >= 2) || r !== ((k >= 2) ? 16'd10 : 16'd0) || l !== (k >= 6)) begin
                err_cnt++;
                $display("FAIL %s rise %0d: valid=%b ratio=%0d locked=%b, want %b %0d %b",
                         name, k, v, r, l, (k >= 2), (k >= 2) ? 10 : 0, (k >= 6));
            end
            if (k >= 3) begin
                vec_cnt++;
                if (h !== duty_exp(5)) begin
                    err_cnt++;
                    $display("FAIL %s high_time rise %0d: got %0d want %0d", name, k, h, duty_exp(5));
                end
            end
        end
    endtask

    task automatic test_ratio_change();
        logic v, l;
        logic [15:0] r, h;
        for (int k = 8; k <= 13; k++) begin
            drive_period(0, 12, 6, v, r, l, h);
            vec_cnt++;
            if (v !== 1'b1 || r !== ((k == 8) ? 16'd10 : 16'd12) || l !== (k == 8 || k == 13)) begin
                err_cnt++;
                $display("FAIL ratio_change rise %0d: valid=%b ratio=%0d locked=%b, want 1 %0d %b",
                         k, v, r, l, (k == 8) ? 10 : 12, (k == 8 || k == 13));
            end
        end
    endtask

    task automatic test_timeout();
        logic v, l;
        logic [15:0] r, h;
        for (int k = 1; k <= 6; k++) drive_period(1, 10, 5, v, r, l, h);
        vec_cnt++;
        if (l !== 1'b1 || r !== 16'd10) begin
            err_cnt++;
            $display("FAIL timeout_prelock: locked=%b ratio=%0d, want 1 10", l, r);
        end
        // Counter reaches 255 at posedge 257 after the last rise; the pulse shows after posedge 258.
        repeat (247) @(posedge clk);
        #1;
        vec_cnt++;
        if (to8 !== 1'b0 || lk8 !== 1'b1) begin
            err_cnt++;
            $display("FAIL timeout_early: timeout=%b locked=%b, want 0 1", to8, lk8);
        end
        @(posedge clk); #1;
        vec_cnt++;
        if (to8 !== 1'b1 || lk8 !== 1'b0 || ratio8 !== 8'd10 || st8 !== S_WAIT) begin
            err_cnt++;
            $display("FAIL timeout_pulse: timeout=%b locked=%b ratio=%0d state=%0d, want 1 0 10 S_WAIT",
                     to8, lk8, ratio8, st8);
        end
        @(posedge clk); #1;
        vec_cnt++;
        if (to8 !== 1'b0) begin
            err_cnt++;
            $display("FAIL timeout_width: timeout=%b want 0", to8);
        end
        for (int k = 1; k <= 6; k++) begin
            drive_period(1, 10, 5, v, r, l, h);
            vec_cnt++;
            if (v !== (k >= 2) || r !== 16'd10 || l !== (k >= 6)) begin
                err_cnt++;
                $display("FAIL timeout_reacq rise %0d: valid=%b ratio=%0d locked=%b, want %b 10 %b",
                         k, v, r, l, (k >= 2), (k >= 6));
            end
        end
    endtask

    task automatic test_mid_reset();
        sig_main = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sig_main = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        vec_cnt++;
        if (ratio_main !== 16'd0 || rv_main !== 1'b0 || lk_main !== 1'b0 || to_main !== 1'b0
            || high_main !== 16'd0 || st_main !== S_WAIT) begin
            err_cnt++;
            $display("FAIL mid_reset: ratio=%0d valid=%b locked=%b timeout=%b high=%0d state=%0d",
                     ratio_main, rv_main, lk_main, to_main, high_main, st_main);
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_lock("relock");
    endtask

    task automatic test_duty();
        logic v, l;
        logic [15:0] r, h;
        drive_period(0, 10, 3, v, r, l, h);
        drive_period(0, 10, 5, v, r, l, h);
        vec_cnt++;
        if (h !== duty_exp(3) || r !== 16'd10 || l !== 1'b1) begin
            err_cnt++;
            $display("FAIL duty: high_time=%0d ratio=%0d locked=%b, want %0d 10 1", h, r, l, duty_exp(3));
        end
    endtask

    task automatic test_tolerance();
        int ns [8] = '{10, 11, 10, 9, 10, 11, 13, 10};
        logic v, l;
        logic [15:0] r, h;
        logic [15:0] er;
        for (int k = 1; k <= 8; k++) begin
            drive_period(2, ns[k-1], ns[k-1] / 2, v, r, l, h);
            er = (k >= 2) ? 16'(ns[k-2]) : 16'd0;
            vec_cnt++;
            if (v !== (k >= 2) || r !== er || l !== (k == 6 || k == 7)) begin
                err_cnt++;
                $display("FAIL tolerance rise %0d: valid=%b ratio=%0d locked=%b, want %b %0d %b",
                         k, v, r, l, (k >= 2), er, (k == 6 || k == 7));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        sig_main = 1'b0;
        sig8 = 1'b0;
        sig_tol = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_lock("lock");
        test_ratio_change();
        test_timeout();
        test_mid_reset();
        test_duty();
        test_tolerance();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
